// File: rtl/writeback_queue.sv
// Writeback stage: retires ALU results and in-order load returns onto the single
// register-file write port, tracking outstanding loads in a small FIFO.
module writeback_queue #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 4,
    parameter int REG_AW   = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ex_valid,
    output logic                          ex_ready,
    input  logic [6:0]                    ex_opcode,
    input  logic [2:0]                    ex_funct3,
    input  logic [REG_AW-1:0]             ex_rd,
    input  logic                          ex_wb_reg,
    input  logic [XLEN-1:0]               ex_alu_out,
    input  logic [XLEN-1:0]               dcache_out,
    input  logic                          done,
    output logic                          wb_enable,
    output logic [REG_AW-1:0]             wb_rd_addr,
    output logic [XLEN-1:0]               wb_rd_data,
    output logic [$clog2(LQ_DEPTH):0]     lq_count,
    output logic                          lq_full,
    output logic                          lq_underflow
);
    localparam int OB = $clog2(XLEN/8);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = REG_AW + 3 + OB + 1;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    logic [EW-1:0]     lq_mem_q [LQ_DEPTH];
    logic [EW-1:0]     lq_mem_d [LQ_DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              underflow_q, underflow_d;
    logic              wb_enable_q, wb_enable_d;
    logic [REG_AW-1:0] wb_rd_addr_q, wb_rd_addr_d;
    logic [XLEN-1:0]   wb_rd_data_q, wb_rd_data_d;

    logic              is_load, full, empty, accept, push, pop;
    logic [EW-1:0]     head_entry;
    logic [REG_AW-1:0] h_rd;
    logic [2:0]        h_f3;
    logic [OB-1:0]     h_off;
    logic              h_wb;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       word_v;
    logic [XLEN-1:0]   ld_data;

    always_comb begin
        is_load    = (ex_opcode == OP_LOAD);
        full       = (count_q == CW'(LQ_DEPTH));
        empty      = (count_q == '0);
        // A load return owns the write port, so a writing ALU op must wait.
        ex_ready   = !((ex_valid && !is_load && ex_wb_reg && done) ||
                       (is_load && full && !done));
        accept     = ex_valid && ex_ready;
        push       = accept && is_load;
        pop        = done && !empty;
        head_entry = lq_mem_q[head_q];
        h_rd       = head_entry[EW-1 -: REG_AW];
        h_f3       = head_entry[OB+3 -: 3];
        h_off      = head_entry[OB:1];
        h_wb       = head_entry[0];
    end

    // Offset bits below the access size are dropped, so misaligned accesses round down.
    always_comb begin
        byte_v = 8'(dcache_out >> {h_off, 3'b000});
        half_v = 16'(dcache_out >> {h_off & ~OB'(1), 3'b000});
        word_v = 32'(dcache_out >> {h_off & ~OB'(3), 3'b000});
        case (h_f3)
            3'b000:  ld_data = XLEN'($signed(byte_v));
            3'b001:  ld_data = XLEN'($signed(half_v));
            3'b010:  ld_data = XLEN'($signed(word_v));
            3'b100:  ld_data = XLEN'(byte_v);
            3'b101:  ld_data = XLEN'(half_v);
            3'b110:  ld_data = XLEN'(word_v);
            default: ld_data = dcache_out;
        endcase
    end

    always_comb begin
        lq_mem_d     = lq_mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        underflow_d  = underflow_q | (done && empty);
        wb_enable_d  = 1'b0;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_rd_data_d = wb_rd_data_q;
        if (push) begin
            lq_mem_d[tail_q] = {ex_rd, ex_funct3, ex_alu_out[OB-1:0], ex_wb_reg};
            tail_d           = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (pop) begin
            if (h_wb && h_rd != '0) begin
                wb_enable_d  = 1'b1;
                wb_rd_addr_d = h_rd;
                wb_rd_data_d = ld_data;
            end
        end else if (accept && !is_load && ex_wb_reg && ex_rd != '0) begin
            wb_enable_d  = 1'b1;
            wb_rd_addr_d = ex_rd;
            wb_rd_data_d = ex_alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_mem_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            underflow_q  <= 1'b0;
            wb_enable_q  <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_rd_data_q <= '0;
        end else begin
            lq_mem_q     <= lq_mem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            underflow_q  <= underflow_d;
            wb_enable_q  <= wb_enable_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_rd_data_q <= wb_rd_data_d;
        end
    end

    assign wb_enable    = wb_enable_q;
    assign wb_rd_addr   = wb_rd_addr_q;
    assign wb_rd_data   = wb_rd_data_q;
    assign lq_count     = count_q;
    assign lq_full      = (count_q == CW'(LQ_DEPTH));
    assign lq_underflow = underflow_q;
endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed bench for writeback_queue against a queue-based
// behavioural model of load ordering, extraction and port arbitration.
module tb_writeback_queue;
    localparam int XLEN = 32;
    localparam int LQ_DEPTH = 4;
    localparam int REG_AW = 5;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ex_valid = 1'b0, ex_ready, ex_wb_reg = 1'b0, done = 1'b0;
    logic [6:0] ex_opcode = '0;
    logic [2:0] ex_funct3 = '0;
    logic [REG_AW-1:0] ex_rd = '0;
    logic [XLEN-1:0] ex_alu_out = '0, dcache_out = '0;
    logic wb_enable, lq_full, lq_underflow;
    logic [REG_AW-1:0] wb_rd_addr;
    logic [XLEN-1:0] wb_rd_data;
    logic [$clog2(LQ_DEPTH):0] lq_count;

    writeback_queue #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .ex_wb_reg(ex_wb_reg), .ex_alu_out(ex_alu_out), .dcache_out(dcache_out),
        .done(done), .wb_enable(wb_enable), .wb_rd_addr(wb_rd_addr),
        .wb_rd_data(wb_rd_data), .lq_count(lq_count), .lq_full(lq_full),
        .lq_underflow(lq_underflow));

    always #5 clk = ~clk;

    typedef struct {
        int rd;
        int f3;
        int off;
        bit wb;
    } ld_t;

    ld_t q[$];
    int  checks = 0;
    int  failures = 0;
    bit  exp_en = 0, exp_uf = 0, last_ready = 0;
    logic [REG_AW-1:0] exp_addr = '0;
    logic [XLEN-1:0]   exp_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_extract(input logic [XLEN-1:0] dc, input int f3, input int off);
        int size;
        bit sgn;
        int a;
        longint unsigned v;
        case (f3)
            0: begin size = 1; sgn = 1; end
            1: begin size = 2; sgn = 1; end
            2: begin size = 4; sgn = 1; end
            4: begin size = 1; sgn = 0; end
            5: begin size = 2; sgn = 0; end
            6: begin size = 4; sgn = 0; end
            default: return dc;
        endcase
        a = off - (off % size);
        v = (longint'(dc) >> (8 * a)) & ((64'd1 << (8 * size)) - 1);
        if (sgn && v >= (64'd1 << (8 * size - 1)))
            v = v - (64'd1 << (8 * size));
        return XLEN'(v);
    endfunction

    // One clock cycle: drive inputs, check ex_ready, advance model, check outputs.
    task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [REG_AW-1:0] rd, input logic wbr,
                        input logic [XLEN-1:0] alu, input logic [XLEN-1:0] dc,
                        input logic dn, input logic r);
        bit ld, exp_ready, acc;
        ld_t e;
        @(negedge clk);
        rst = r; ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_rd = rd;
        ex_wb_reg = wbr; ex_alu_out = alu; dcache_out = dc; done = dn;
        #1;
        ld = (op == OP_LOAD);
        exp_ready = !((v && !ld && wbr && dn) || (ld && q.size() == LQ_DEPTH && !dn));
        last_ready = ex_ready;
        if (r) begin
            q.delete();
            exp_en = 0; exp_addr = '0; exp_data = '0; exp_uf = 0;
        end else begin
            check("ex_ready", ex_ready, exp_ready);
            acc = v && exp_ready;
            exp_en = 0;
            if (dn) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    if (e.wb && e.rd != 0) begin
                        exp_en = 1; exp_addr = REG_AW'(e.rd);
                        exp_data = ref_extract(dc, e.f3, e.off);
                    end
                end else begin
                    exp_uf = 1;
                end
            end
            if (acc && ld) begin
                e.rd = int'(rd); e.f3 = int'(f3); e.off = int'(alu[1:0]); e.wb = wbr;
                q.push_back(e);
            end else if (acc && wbr && rd != 0) begin
                exp_en = 1; exp_addr = rd; exp_data = alu;
            end
        end
        @(posedge clk);
        #1;
        check("wb_enable", wb_enable, exp_en);
        check("wb_rd_addr", wb_rd_addr, exp_addr);
        check("wb_rd_data", wb_rd_data, exp_data);
        check("lq_count", lq_count, q.size());
        check("lq_full", lq_full, q.size() == LQ_DEPTH);
        check("lq_underflow", lq_underflow, exp_uf);
    endtask

    task automatic idle(input logic dn, input logic [XLEN-1:0] dc);
        step(0, 7'd0, 3'd0, '0, 0, '0, dc, dn, 0);
    endtask

    task automatic do_reset();
        step(0, 7'd0, 3'd0, '0, 0, '0, '0, 0, 1);
        step(1, OP_LOAD, 3'd0, 5'd1, 1, '0, '0, 1, 1);
    endtask

    initial begin
        do_reset();

        // ALU write
        step(1, OP_ALU, 3'd0, 5'd5, 1, 32'h1234_5678, '0, 0, 0);
        check("alu_en", wb_enable, 1);
        check("alu_data", wb_rd_data, 32'h1234_5678);

        // extraction cases
        step(1, OP_LOAD, 3'b000, 5'd3, 1, 32'h0000_1002, '0, 0, 0);
        idle(1, 32'h80FF_0011);
        check("lb_data", wb_rd_data, 32'hFFFF_FFFF);
        step(1, OP_LOAD, 3'b100, 5'd3, 1, 32'h0000_1002, '0, 0, 0);
        idle(1, 32'h80FF_0011);
        check("lbu_data", wb_rd_data, 32'h0000_00FF);
        step(1, OP_LOAD, 3'b001, 5'd3, 1, 32'h0000_1002, '0, 0, 0);
        idle(1, 32'h80FF_0011);
        check("lh_data", wb_rd_data, 32'hFFFF_80FF);

        // full queue, stall, push+pop at full
        for (int i = 1; i <= 4; i++)
            step(1, OP_LOAD, 3'b010, REG_AW'(i), 1, 32'(i * 4), '0, 0, 0);
        check("full_flag", lq_full, 1);
        step(1, OP_LOAD, 3'b010, 5'd6, 1, '0, '0, 0, 0);
        check("full_stall", last_ready, 0);
        step(1, OP_LOAD, 3'b010, 5'd6, 1, '0, 32'hA5A5_0001, 1, 0);
        check("full_push_pop", last_ready, 1);
        check("full_count", lq_count, 4);
        check("first_ret_rd", wb_rd_addr, 1);
        for (int i = 0; i < 4; i++)
            idle(1, 32'(32'h1000 + i));
        check("last_ret_rd", wb_rd_addr, 6);

        // done vs ALU arbitration
        step(1, OP_LOAD, 3'b010, 5'd7, 1, '0, '0, 0, 0);
        step(1, OP_ALU, 3'd0, 5'd9, 1, 32'hABCD, 32'h7777, 1, 0);
        check("arb_stall", last_ready, 0);
        check("arb_load_rd", wb_rd_addr, 7);
        step(1, OP_ALU, 3'd0, 5'd9, 1, 32'hABCD, '0, 0, 0);
        check("arb_alu_rd", wb_rd_addr, 9);
        step(1, OP_LOAD, 3'b010, 5'd8, 1, '0, '0, 0, 0);
        step(1, OP_ALU, 3'd0, 5'd10, 0, 32'h5555, 32'h8888, 1, 0);
        check("nowb_accept", last_ready, 1);
        check("nowb_load_rd", wb_rd_addr, 8);

        // underflow and rd=0
        idle(1, '0);
        check("uf_set", lq_underflow, 1);
        idle(0, '0);
        check("uf_sticky", lq_underflow, 1);
        do_reset();
        step(1, OP_LOAD, 3'b010, 5'd0, 1, '0, '0, 0, 0);
        idle(1, 32'hDEAD_BEEF);
        check("rd0_no_write", wb_enable, 0);

        // reset with loads outstanding
        step(1, OP_LOAD, 3'b010, 5'd11, 1, '0, '0, 0, 0);
        step(1, OP_LOAD, 3'b010, 5'd12, 1, '0, '0, 0, 0);
        do_reset();
        check("rst_count", lq_count, 0);
        idle(1, 32'h1);
        check("rst_uf", lq_underflow, 1);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] op;
            logic dn;
            op = ($urandom_range(0, 1) == 1) ? OP_LOAD :
                 (($urandom_range(0, 1) == 1) ? OP_ALU : 7'($urandom));
            dn = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 3) != 0, op, 3'($urandom), 5'($urandom),
                 $urandom_range(0, 4) != 0, 32'($urandom), 32'($urandom), dn,
                 $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
